// File: rtl/noc_router_output_port.sv
// Router output port: latches a packet header, drains payload bytes from a small FIFO
// and emits one flit per byte toward the downstream input port.
module noc_router_output_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [1:0]  msg_dst,
  input  logic [1:0]  msg_type,
  input  logic [2:0]  msg_len,
  input  logic        pl_valid,
  input  logic [7:0]  pl_data,
  output logic        pl_ready,
  output logic [13:0] packet,
  output logic        packet_valid,
  input  logic        dst_ready,
  output logic        busy,
  output logic [7:0]  pkt_count
);

  // state | meaning
  // IDLE  | waiting for a header; payload may still be queued
  // SEND  | emitting flits of the latched header, one per queued byte

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state, state_next;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop, hdr_fire;
  logic [1:0]  dst_q, type_q;
  logic [2:0]  len_q, index;
  logic        flit_sop, flit_eop;
  logic [7:0]  fifo_head;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = mem[rd_ptr[AW-1:0]];

  assign pl_ready     = !fifo_full;
  assign push         = pl_valid && !fifo_full;
  assign packet_valid = (state == SEND) && !fifo_empty;
  assign pop          = packet_valid && dst_ready;
  assign hdr_fire     = msg_valid && msg_ready;
  assign flit_sop     = (index == 3'd0);
  assign flit_eop     = (index == len_q);
  assign packet       = packet_valid ? {flit_sop, dst_q, type_q, fifo_head, flit_eop} : 14'h0000;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (msg_valid) state_next = SEND;
      SEND:    if (pop && flit_eop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    msg_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    msg_ready = 1'b1;
      SEND:    busy      = 1'b1;
      default: msg_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pl_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dst_q     <= 2'd0;
      type_q    <= 2'd0;
      len_q     <= 3'd0;
      index     <= 3'd0;
      pkt_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (hdr_fire) begin
        dst_q  <= msg_dst;
        type_q <= msg_type;
        len_q  <= msg_len;
        index  <= 3'd0;
      end else if (pop) begin
        index <= index + 3'd1;
        if (flit_eop) pkt_count <= pkt_count + 8'd1;
      end
    end
  end

endmodule
